psram_arbiter: RTL and testbench



---
 rtl/psram_pkg.sv | 19 +
 rtl/psram_req_latch.sv | 51 +++++
 rtl/psram_arbiter.sv | 150 +++++++++++++++
 tb/tb_psram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM front end: bus widths, arbiter FSM states
// and requester identifiers.
package psram_pkg;

  localparam int PSRAM_ADDR_W = 22;
  localparam int PSRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/psram_req_latch.sv
// Per-port pending request latch. A request arriving while the port is ready
// is presented straight through so the arbiter can issue it without a wait cycle.
module psram_req_latch
  import psram_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    wr,
  input  logic [PSRAM_ADDR_W-1:0] address,
  input  logic [PSRAM_DATA_W-1:0] wdata,
  input  logic                    in_flight,
  input  logic                    grant,
  output logic                    ready,
  output logic                    valid,
  output logic                    op_wr,
  output logic [PSRAM_ADDR_W-1:0] op_address,
  output logic [PSRAM_DATA_W-1:0] op_wdata
);

  logic                    pending;
  logic                    pend_wr;
  logic [PSRAM_ADDR_W-1:0] pend_address;
  logic [PSRAM_DATA_W-1:0] pend_wdata;
  logic                    accept;

  assign ready      = !pending && !in_flight;
  assign accept     = req && ready;
  assign valid      = pending || accept;
  assign op_wr      = pending ? pend_wr      : wr;
  assign op_address = pending ? pend_address : address;
  assign op_wdata   = pending ? pend_wdata   : wdata;

  // A granted request leaves the latch, even one that was only just accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= 1'b0;
      pend_wr      <= 1'b0;
      pend_address <= '0;
      pend_wdata   <= '0;
    end else begin
      if (accept) begin
        pend_wr      <= wr;
        pend_address <= address;
        pend_wdata   <= wdata;
      end
      pending <= valid && !grant;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter in front of the PSRAM controller; serialises
// single-byte requests and routes completions back to the issuing port.
module psram_arbiter
  import psram_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic                    a_wr,
  input  logic [PSRAM_ADDR_W-1:0] a_address,
  input  logic [PSRAM_DATA_W-1:0] a_wdata,
  output logic                    a_ready,
  output logic [PSRAM_DATA_W-1:0] a_rdata,
  output logic                    a_rdata_en,
  output logic                    a_done,
  input  logic                    b_req,
  input  logic                    b_wr,
  input  logic [PSRAM_ADDR_W-1:0] b_address,
  input  logic [PSRAM_DATA_W-1:0] b_wdata,
  output logic                    b_ready,
  output logic [PSRAM_DATA_W-1:0] b_rdata,
  output logic                    b_rdata_en,
  output logic                    b_done,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [PSRAM_ADDR_W-1:0] mem_address,
  output logic [PSRAM_DATA_W-1:0] mem_wdata,
  input  logic                    mem_busy,
  input  logic [PSRAM_DATA_W-1:0] mem_rdata,
  input  logic                    mem_rdata_en
);

  state_t state;
  port_t  cur_port;
  port_t  last_grant;
  logic   cur_wr;

  logic                    a_valid, b_valid;
  logic                    a_op_wr, b_op_wr;
  logic [PSRAM_ADDR_W-1:0] a_op_address, b_op_address;
  logic [PSRAM_DATA_W-1:0] a_op_wdata, b_op_wdata;
  logic                    grant_a, grant_b, issue;
  logic                    sel_wr;
  logic [PSRAM_ADDR_W-1:0] sel_address;
  logic [PSRAM_DATA_W-1:0] sel_wdata;

  // On a tie the port that did not win last time goes first.
  assign grant_a     = a_valid && (!b_valid || last_grant == PORT_B);
  assign grant_b     = b_valid && !grant_a;
  assign issue       = (state == ST_IDLE) && !mem_busy && (a_valid || b_valid);
  assign sel_wr      = grant_a ? a_op_wr      : b_op_wr;
  assign sel_address = grant_a ? a_op_address : b_op_address;
  assign sel_wdata   = grant_a ? a_op_wdata   : b_op_wdata;

  psram_req_latch u_latch_a (
    .clk        (clk),
    .reset      (reset),
    .req        (a_req),
    .wr         (a_wr),
    .address    (a_address),
    .wdata      (a_wdata),
    .in_flight  ((state != ST_IDLE) && (cur_port == PORT_A)),
    .grant      (issue && grant_a),
    .ready      (a_ready),
    .valid      (a_valid),
    .op_wr      (a_op_wr),
    .op_address (a_op_address),
    .op_wdata   (a_op_wdata)
  );

  psram_req_latch u_latch_b (
    .clk        (clk),
    .reset      (reset),
    .req        (b_req),
    .wr         (b_wr),
    .address    (b_address),
    .wdata      (b_wdata),
    .in_flight  ((state != ST_IDLE) && (cur_port == PORT_B)),
    .grant      (issue && grant_b),
    .ready      (b_ready),
    .valid      (b_valid),
    .op_wr      (b_op_wr),
    .op_address (b_op_address),
    .op_wdata   (b_op_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_port    <= PORT_A;
      last_grant  <= PORT_B;
      cur_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      a_rdata     <= '0;
      a_rdata_en  <= 1'b0;
      a_done      <= 1'b0;
      b_rdata     <= '0;
      b_rdata_en  <= 1'b0;
      b_done      <= 1'b0;
    end else begin
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      a_rdata_en <= 1'b0;
      a_done     <= 1'b0;
      b_rdata_en <= 1'b0;
      b_done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            cur_port    <= grant_a ? PORT_A : PORT_B;
            last_grant  <= grant_a ? PORT_A : PORT_B;
            cur_wr      <= sel_wr;
            mem_rd      <= !sel_wr;
            mem_wr      <= sel_wr;
            mem_address <= sel_address;
            mem_wdata   <= sel_wdata;
            state       <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (mem_busy) state <= ST_DONE;
        end
        // Reads finish only on returned data; busy dropping alone is not enough.
        ST_DONE: begin
          if (cur_wr) begin
            if (!mem_busy) begin
              a_done <= (cur_port == PORT_A);
              b_done <= (cur_port == PORT_B);
              state  <= ST_IDLE;
            end
          end else if (mem_rdata_en) begin
            if (cur_port == PORT_A) begin
              a_rdata    <= mem_rdata;
              a_rdata_en <= 1'b1;
            end else begin
              b_rdata    <= mem_rdata;
              b_rdata_en <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small behavioural PSRAM controller
// model and a command monitor.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_wr = 1'b0;
  logic [21:0] a_address = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_ready, a_rdata_en, a_done;
  logic [7:0]  a_rdata;
  logic        b_req = 1'b0, b_wr = 1'b0;
  logic [21:0] b_address = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_ready, b_rdata_en, b_done;
  logic [7:0]  b_rdata;
  logic        mem_rd, mem_wr, mem_busy, mem_rdata_en;
  logic [21:0] mem_address;
  logic [7:0]  mem_wdata, mem_rdata;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  psram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_wr         (a_wr),
    .a_address    (a_address),
    .a_wdata      (a_wdata),
    .a_ready      (a_ready),
    .a_rdata      (a_rdata),
    .a_rdata_en   (a_rdata_en),
    .a_done       (a_done),
    .b_req        (b_req),
    .b_wr         (b_wr),
    .b_address    (b_address),
    .b_wdata      (b_wdata),
    .b_ready      (b_ready),
    .b_rdata      (b_rdata),
    .b_rdata_en   (b_rdata_en),
    .b_done       (b_done),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_busy     (mem_busy),
    .mem_rdata    (mem_rdata),
    .mem_rdata_en (mem_rdata_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy from the cycle after a command for busy_len cycles;
  // a read returns its byte in the cycle busy falls.
  int          busy_len = 12;
  logic        hold = 1'b0;
  logic        busy_r;
  int          busy_cnt;
  logic        is_rd;
  logic [21:0] lat_addr;

  function automatic logic [7:0] model_rdata(input logic [21:0] addr);
    return (addr == 22'h00010) ? 8'hC3 : (addr[7:0] ^ 8'hA5);
  endfunction

  assign mem_busy = busy_r | hold;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r       <= 1'b0;
      busy_cnt     <= 0;
      is_rd        <= 1'b0;
      lat_addr     <= '0;
      mem_rdata    <= '0;
      mem_rdata_en <= 1'b0;
    end else begin
      mem_rdata_en <= 1'b0;
      if (mem_rd || mem_wr) begin
        busy_r   <= 1'b1;
        busy_cnt <= busy_len;
        is_rd    <= mem_rd;
        lat_addr <= mem_address;
      end else if (busy_r) begin
        if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
        else begin
          busy_r <= 1'b0;
          if (is_rd) begin
            mem_rdata_en <= 1'b1;
            mem_rdata    <= model_rdata(lat_addr);
          end
        end
      end
    end
  end

  logic        cmd_wr_q[$];
  logic [21:0] cmd_addr_q[$];
  logic [7:0]  cmd_data_q[$];
  int   viol = 0;
  int   busy_fall_cyc = -1, rdata_en_cyc = -1;
  int   a_rd_cnt = 0, a_done_cnt = 0, b_rd_cnt = 0, b_done_cnt = 0;
  logic prev_cmd = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      cmd_wr_q.push_back(mem_wr);
      cmd_addr_q.push_back(mem_address);
      cmd_data_q.push_back(mem_wdata);
    end
    if ((mem_rd && mem_wr) || ((mem_rd || mem_wr) && prev_cmd)) viol <= viol + 1;
    prev_cmd <= mem_rd || mem_wr;
    if (prev_busy && !mem_busy) busy_fall_cyc <= cyc;
    prev_busy <= mem_busy;
    if (mem_rdata_en) rdata_en_cyc <= cyc;
    if (a_rdata_en) a_rd_cnt <= a_rd_cnt + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_rdata_en) b_rd_cnt <= b_rd_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic use_a, input logic use_b, input logic wr,
                               input logic [21:0] addr_a, input logic [21:0] addr_b,
                               input logic [7:0] data_a, input logic [7:0] data_b);
    a_req = use_a; a_wr = wr; a_address = addr_a; a_wdata = data_a;
    b_req = use_b; b_wr = wr; b_address = addr_b; b_wdata = data_b;
    step(1);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // which: 0 a_done, 1 a_rdata_en, 2 b_done, 3 b_rdata_en
  task automatic waitFor(input int which, input int limit, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step(1);
      case (which)
        0: got = a_done;
        1: got = a_rdata_en;
        2: got = b_done;
        default: got = b_rdata_en;
      endcase
    end
    checkOutput(tag, {31'd0, got}, 32'd1);
  endtask

  int base_q, base_cnt;

  initial begin
    step(3);
    checkOutput("rst_a_ready", {31'd0, a_ready}, 1);
    checkOutput("rst_b_ready", {31'd0, b_ready}, 1);
    checkOutput("rst_mem_cmd", {30'd0, mem_rd, mem_wr}, 0);
    checkOutput("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
    checkOutput("rst_mem_addr", {10'd0, mem_address}, 0);
    reset = 1'b0;
    step(2);

    // Port A write with a 12-cycle busy controller
    busy_len = 12;
    applyStimulus(1, 0, 1, 22'h12345, 22'h0, 8'h5A, 8'h0);
    checkOutput("w_mem_wr", {31'd0, mem_wr}, 1);
    checkOutput("w_mem_addr", {10'd0, mem_address}, 32'h12345);
    checkOutput("w_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
    checkOutput("w_a_ready_low", {31'd0, a_ready}, 0);
    step(1);
    checkOutput("w_busy_cycle2", {30'd0, mem_busy, mem_wr}, 2);
    waitFor(0, 40, "w_a_done_seen");
    checkOutput("w_done_latency", cyc, busy_fall_cyc + 1);
    checkOutput("w_ready_at_done", {31'd0, a_ready}, 1);
    step(1);
    checkOutput("w_ready_after", {30'd0, a_ready, a_done}, 2);
    checkOutput("w_cmd_count", cmd_wr_q.size(), 1);

    // Port B read returns 0xC3
    applyStimulus(0, 1, 0, 22'h0, 22'h00010, 8'h0, 8'h0);
    checkOutput("r_mem_rd", {31'd0, mem_rd}, 1);
    checkOutput("r_mem_addr", {10'd0, mem_address}, 32'h10);
    waitFor(3, 40, "r_b_rdata_en_seen");
    checkOutput("r_b_rdata", {24'd0, b_rdata}, 32'hC3);
    checkOutput("r_latency", cyc, rdata_en_cyc + 1);
    step(1);
    checkOutput("r_a_rdata_en_none", a_rd_cnt, 0);

    // Simultaneous requests, with a lone A op between the two ties
    busy_len = 4;
    base_q = cmd_addr_q.size();
    applyStimulus(1, 1, 1, 22'h00100, 22'h00200, 8'h11, 8'h22);
    waitFor(2, 60, "tie1_b_done_seen");
    step(2);
    applyStimulus(1, 0, 1, 22'h00300, 22'h0, 8'h33, 8'h0);
    waitFor(0, 60, "lone_a_done_seen");
    step(2);
    applyStimulus(1, 1, 1, 22'h00400, 22'h00500, 8'h44, 8'h55);
    waitFor(0, 60, "tie2_a_done_seen");
    step(2);
    checkOutput("tie_cmd_count", cmd_addr_q.size() - base_q, 5);
    checkOutput("tie_order0", {10'd0, cmd_addr_q[base_q]}, 32'h100);
    checkOutput("tie_order1", {10'd0, cmd_addr_q[base_q+1]}, 32'h200);
    checkOutput("tie_order3", {10'd0, cmd_addr_q[base_q+3]}, 32'h500);
    checkOutput("tie_order4", {10'd0, cmd_addr_q[base_q+4]}, 32'h400);
    checkOutput("tie_wdata3", {24'd0, cmd_data_q[base_q+3]}, 32'h55);

    // Power-up busy hold with A pending, plus an ignored second A request
    busy_len = 6;
    hold = 1'b1;
    base_q = cmd_addr_q.size();
    base_cnt = a_done_cnt;
    applyStimulus(1, 0, 0, 22'h2AAAA, 22'h0, 8'h0, 8'h0);
    checkOutput("hold_a_ready_low", {31'd0, a_ready}, 0);
    applyStimulus(1, 0, 1, 22'h03333, 22'h0, 8'h99, 8'h0);
    step(196);
    checkOutput("hold_no_cmd", cmd_addr_q.size() - base_q, 0);
    hold = 1'b0;
    step(1);
    checkOutput("hold_issue_rd", {31'd0, mem_rd}, 1);
    checkOutput("hold_issue_addr", {10'd0, mem_address}, 32'h2AAAA);
    waitFor(1, 40, "hold_a_rdata_en_seen");
    checkOutput("hold_a_rdata", {24'd0, a_rdata}, 32'h0F);
    step(10);
    checkOutput("dup_single_cmd", cmd_addr_q.size() - base_q, 1);
    checkOutput("dup_no_done", a_done_cnt - base_cnt, 0);

    // Reset during ST_DONE of a port-A read
    busy_len = 20;
    base_cnt = a_rd_cnt;
    applyStimulus(1, 0, 0, 22'h00777, 22'h0, 8'h0, 8'h0);
    step(5);
    reset = 1'b1;
    #2;
    checkOutput("mid_rst_ready", {30'd0, a_ready, b_ready}, 3);
    checkOutput("mid_rst_cmd", {30'd0, mem_rd, mem_wr}, 0);
    checkOutput("mid_rst_a_rdata", {24'd0, a_rdata}, 0);
    checkOutput("mid_rst_mem_addr", {10'd0, mem_address}, 0);
    checkOutput("mid_rst_pulses", {28'd0, a_rdata_en, a_done, b_rdata_en, b_done}, 0);
    step(2);
    reset = 1'b0;
    step(30);
    checkOutput("mid_rst_no_rdata_en", a_rd_cnt - base_cnt, 0);
    checkOutput("post_rst_ready", {30'd0, a_ready, b_ready}, 3);

    checkOutput("cmd_overlap", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
